// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns single-cycle requests into HIGH_CYC-wide levels separated by at least GAP_CYC low cycles, queueing surplus requests.
// Optional build macro PULSE_STRETCHER_RETRIG_EN: a request while high restarts the high window instead of queueing.
module pulse_stretcher #(
    parameter int unsigned HIGH_CYC = 4,
    parameter int unsigned GAP_CYC  = 2,
    parameter int unsigned PEND_W   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              pulse_i,
    output logic              level_o,
    output logic              busy_o,
    output logic [PEND_W-1:0] pending_o,
    output logic              overflow_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    localparam logic [7:0]        HIGH_LD  = 8'(HIGH_CYC - 1);
    localparam logic [7:0]        GAP_LD   = 8'(GAP_CYC - 1);
    localparam logic [PEND_W-1:0] PEND_MAX = '1;

    state_t            r_state, w_state_nx;
    logic [7:0]        r_cnt, w_cnt_nx;
    logic [PEND_W-1:0] r_pend, w_pend_nx;
    logic              r_level, r_ovf, w_ovf_nx;
    logic              w_retrig, w_queue, w_take;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_pend  <= '0;
            r_level <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
            r_pend  <= w_pend_nx;
            r_level <= (w_state_nx == S_HIGH);
            r_ovf   <= w_ovf_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_cnt_nx   = r_cnt;
        w_pend_nx  = r_pend;
        w_ovf_nx   = 1'b0;
        w_retrig   = 1'b0;
`ifdef PULSE_STRETCHER_RETRIG_EN
        w_retrig   = pulse_i && (r_state == S_HIGH);
`endif
        w_queue = pulse_i && (r_state != S_IDLE) && !w_retrig;
        // A request on the last gap cycle is serviced at once, even when nothing was pending.
        w_take  = (r_state == S_GAP) && (r_cnt == 8'd0) && ((r_pend != '0) || w_queue);

        if (w_queue && !w_take) begin
            if (r_pend == PEND_MAX) w_ovf_nx = 1'b1;
            else                    w_pend_nx = r_pend + 1'b1;
        end else if (!w_queue && w_take) begin
            w_pend_nx = r_pend - 1'b1;
        end

        case (r_state)
            S_IDLE: begin
                if (pulse_i) begin
                    w_state_nx = S_HIGH;
                    w_cnt_nx   = HIGH_LD;
                end
            end
            S_HIGH: begin
                if (w_retrig) begin
                    w_cnt_nx = HIGH_LD;
                end else if (r_cnt == 8'd0) begin
                    w_state_nx = S_GAP;
                    w_cnt_nx   = GAP_LD;
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            S_GAP: begin
                if (r_cnt == 8'd0) begin
                    if (w_take) begin
                        w_state_nx = S_HIGH;
                        w_cnt_nx   = HIGH_LD;
                    end else begin
                        w_state_nx = S_IDLE;
                    end
                end else begin
                    w_cnt_nx = r_cnt - 8'd1;
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = '0;
            end
        endcase
    end

    assign level_o    = r_level;
    assign busy_o     = (r_state != S_IDLE);
    assign pending_o  = r_pend;
    assign overflow_o = r_ovf;

endmodule
